// File: rtl/mult_pkg.sv
// mult_pkg: shared types, defaults and the Baugh-Wooley correction constant
package mult_pkg;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    typedef logic [$clog2(DEFAULT_WIDTH)-1:0] row_idx_t;

    // 2^width + 2^(2*width-1); callers slice it down to 2*width bits (width <= 64)
    function automatic logic [127:0] bw_correction(input int width);
        return (128'd1 << width) | (128'd1 << (2 * width - 1));
    endfunction
endpackage

// File: rtl/pp_row_accumulator_if.sv
// pp_row_accumulator_if: row input handshake, product output handshake, flush and busy
interface pp_row_accumulator_if #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_row;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic                 busy;

    modport master (
        output flush, in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_product, busy
    );

    modport slave (
        input  flush, in_valid, in_row, out_ready,
        output in_ready, out_valid, out_product, busy
    );
endinterface

// File: rtl/pp_row_align.sv
// pp_row_align: zero-extend a partial-product row and shift it to its weight
module pp_row_align #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         row,
    input  logic [$clog2(WIDTH)-1:0] shift,
    output logic [2*WIDTH-1:0]       aligned
);
    assign aligned = {{WIDTH{1'b0}}, row} << shift;
endmodule

// File: rtl/pp_row_accumulator.sv
// pp_row_accumulator: serially sums Baugh-Wooley rows into a signed 2*WIDTH-bit product
module pp_row_accumulator
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    pp_row_accumulator_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [2*WIDTH-1:0] CORR = (2*WIDTH)'(bw_correction(WIDTH));

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               rdy_q, rdy_d;
    logic [2*WIDTH-1:0] aligned;
    logic [2*WIDTH-1:0] sum;
    logic               accept;
    logic               last_row;

    pp_row_align #(.WIDTH(WIDTH)) u_align (
        .row     (bus.in_row),
        .shift   (idx_q),
        .aligned (aligned)
    );

    // rdy_q keeps in_ready low until the first clock after reset release
    assign bus.in_ready    = rdy_q && (state_q != DONE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_product = prod_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign last_row = (idx_q == IW'(WIDTH - 1));
    // the first row of a product starts from the correction constant instead of acc
    assign sum      = ((state_q == IDLE) ? CORR : acc_q) + aligned;

    // next state, accumulator, row index and held product; flush overrides everything
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        prod_d  = prod_q;
        rdy_d   = 1'b1;
        if (bus.flush) begin
            state_d = IDLE;
            acc_d   = '0;
            idx_d   = '0;
        end else if (accept) begin
            acc_d   = sum;
            idx_d   = idx_q + 1'b1;
            state_d = ACCUM;
            if (state_q == ACCUM && last_row) begin
                state_d = DONE;
                idx_d   = '0;
                prod_d  = sum;
            end
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    // state register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            prod_q  <= '0;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            idx_q   <= idx_d;
            rdy_q   <= rdy_d;
        end
    end
endmodule

// File: tb/tb_pp_row_accumulator.sv
// tb_pp_row_accumulator: scoreboard bench against signed multiplication of the operands
module tb_pp_row_accumulator;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_out = 0;
    int   rmode = 0;
    logic [2*W-1:0] sb[$];

    pp_row_accumulator_if #(.WIDTH(W)) bus();

    pp_row_accumulator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // downstream ready: 0 = always ready, 1 = random, 2 = held low
    always @(posedge clk) begin
        #1;
        bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // producer model: row i is A masked by B[i], with the Baugh-Wooley inversions
    function automatic logic [W-1:0] bw_row(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
        logic [W-1:0] r;
        r = b[i] ? a : '0;
        if (i < W - 1) r[W-1] = ~r[W-1];
        else r[W-2:0] = ~r[W-2:0];
        return r;
    endfunction

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p;
    endfunction

    function automatic void push(input logic [W-1:0] a, input logic [W-1:0] b);
        sb.push_back(model(a, b));
        n_push++;
    endfunction

    // monitor: every output handshake pops one expected product
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("product", bus.out_product, sb.pop_front());
            n_out++;
        end
    end

    // called at posedge+1; returns at posedge+1 after the edge that accepted the row
    task automatic wait_accept();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic send_rows(input logic [W-1:0] a, input logic [W-1:0] b, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_row   = W'($urandom);
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_row   = bw_row(a, b, i);
            wait_accept();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && sb.size() != 0; t++) @(posedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2*W-1:0] held;
        logic [W-1:0] a, b;
        int c0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_product", bus.out_product, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_held", bus.in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_release", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // 3 x 5 back to back: out_valid right after the 16th consecutive accept
        check("row0_3x5", bw_row(16'd3, 16'd5, 0), 16'h8003);
        check("row15_3x5", bw_row(16'd3, 16'd5, 15), 16'h7FFF);
        push(16'd3, 16'd5);
        c0 = cyc;
        send_rows(16'd3, 16'd5, 16, 1'b0);
        check("latency_cycles", 64'(cyc - c0), 64'd16);
        @(negedge clk);
        check("out_valid_latency", bus.out_valid, 1);
        check("in_ready_done", bus.in_ready, 0);
        check("product_3x5", bus.out_product, 32'h0000000F);
        @(posedge clk);
        #1;

        // corner operands with stalls and random downstream ready
        rmode = 1;
        push(16'hFFFF, 16'hFFFF);
        send_rows(16'hFFFF, 16'hFFFF, 16, 1'b1);
        push(16'h8000, 16'h8000);
        send_rows(16'h8000, 16'h8000, 16, 1'b1);
        push(16'h7FFF, 16'h8000);
        send_rows(16'h7FFF, 16'h8000, 16, 1'b1);
        check("model_ffff", model(16'hFFFF, 16'hFFFF), 32'h00000001);
        check("model_8000", model(16'h8000, 16'h8000), 32'h40000000);
        check("model_7fff", model(16'h7FFF, 16'h8000), 32'hC0008000);
        drain();

        // hold out_ready low for 5 cycles in DONE
        rmode = 2;
        a = W'($urandom);
        b = W'($urandom);
        push(a, b);
        send_rows(a, b, 16, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_row   = bw_row(a, b, 0);
        @(negedge clk);
        held = bus.out_product;
        check("hold_value", held, model(a, b));
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_stable", bus.out_product, held);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rmode = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_deliver", bus.in_ready, 1);
        check("out_valid_after_deliver", bus.out_valid, 0);
        check("product_kept", bus.out_product, held);
        @(posedge clk);
        #1;

        // flush after row 7 with a row presented in the flush cycle
        send_rows(16'd3, 16'd5, 8, 1'b0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_row   = bw_row(16'd3, 16'd5, 8);
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", bus.busy, 0);
        check("flush_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        push(16'd3, 16'd5);
        send_rows(16'd3, 16'd5, 16, 1'b0);
        drain();

        // asynchronous reset in the middle of row 9
        a = W'($urandom);
        b = W'($urandom);
        send_rows(a, b, 9, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_row   = bw_row(a, b, 9);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_product", bus.out_product, 0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(16'hFFFF, 16'h0002);
        check("model_m1x2", model(16'hFFFF, 16'h0002), 32'hFFFFFFFE);
        send_rows(16'hFFFF, 16'h0002, 16, 1'b0);
        drain();

        // random operands, random stalls and random downstream ready
        rmode = 1;
        for (int n = 0; n < 1000; n++) begin
            a = ($urandom_range(0, 7) == 0) ? W'(16'h8000 + $urandom_range(0, 1) * 16'h7FFF) : W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? W'(16'h8000 + $urandom_range(0, 1) * 16'h7FFF) : W'($urandom);
            push(a, b);
            send_rows(a, b, 16, 1'b1);
        end
        drain();
        rmode = 0;
        check("handshake_count", 64'(n_out), 64'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
